maze_game_core: RTL and testbench

- Parametrised game engine for the LED-matrix maze, for square maps of any size MAP_DIM.
- Owns the player position, wall/edge collision checking, a two-digit BCD step counter, a BCD countdown timer and an IDLE/PLAY/WIN/LOSE state machine.
- Takes debounced single-cycle direction pulses and a 1 Hz tick enable from upstream.
- Feeds the matrix scanner and the seven-segment driver.
- New over the previous generation: any map size, map and endpoints supplied as inputs, explicit win/lose states, bump reporting, multi-key rejection, step saturation and restart at any time.

---
 rtl/maze_pkg.sv | 24 ++
 rtl/maze_game_core_if.sv | 39 +++
 rtl/bcd2_counter.sv | 34 +++
 rtl/maze_game_core.sv | 138 +++++++++++++
 tb/tb_maze_game_core.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/maze_pkg.sv
// Shared encodings for the LED-matrix maze engine: game states, move
// direction bit positions and BCD helpers.
package maze_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_WIN  = 2'b10,
    ST_LOSE = 2'b11
  } state_t;

  localparam int DIR_DOWN  = 0;
  localparam int DIR_UP    = 1;
  localparam int DIR_LEFT  = 2;
  localparam int DIR_RIGHT = 3;

  localparam logic [7:0] BCD_MAX = 8'h99;

  // Elaboration-time conversion of a 0..99 constant into {tens,ones}.
  function automatic logic [7:0] to_bcd(input int value);
    return {4'(value / 10), 4'(value % 10)};
  endfunction

endpackage

// File: rtl/maze_game_core_if.sv
// Control/status bundle between the maze engine and its neighbours
// (input conditioning upstream, matrix scanner and 7-segment driver downstream).
interface maze_game_core_if #(
  parameter int MAP_DIM = 8
);
  localparam int CW = $clog2(MAP_DIM);

  // Strobe semantics: start, move and tick carry no ready; each is a
  // single-cycle valid that the engine consumes on the rising edge where it
  // is high. All status signals are registered and valid every cycle.
  logic                       start;
  logic [MAP_DIM*MAP_DIM-1:0] wall_map;
  logic [CW-1:0]              start_row;
  logic [CW-1:0]              start_col;
  logic [CW-1:0]              goal_row;
  logic [CW-1:0]              goal_col;
  logic [3:0]                 move;
  logic                       tick;

  logic [1:0]                 state_o;
  logic [CW-1:0]              row_o;
  logic [CW-1:0]              col_o;
  logic [7:0]                 steps_bcd;
  logic [7:0]                 time_bcd;
  logic                       win_o;
  logic                       lose_o;
  logic                       bump_o;

  modport master (
    output start, wall_map, start_row, start_col, goal_row, goal_col, move, tick,
    input  state_o, row_o, col_o, steps_bcd, time_bcd, win_o, lose_o, bump_o
  );

  modport slave (
    input  start, wall_map, start_row, start_col, goal_row, goal_col, move, tick,
    output state_o, row_o, col_o, steps_bcd, time_bcd, win_o, lose_o, bump_o
  );

endinterface

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter: load beats inc beats dec; inc sticks at 99, dec at 00.
module bcd2_counter
  import maze_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       inc,
  input  logic       dec,
  output logic [7:0] q
);

  logic [7:0] q_next;

  always_comb begin
    q_next = q;
    if (load) begin
      q_next = load_val;
    end else if (inc && q != BCD_MAX) begin
      if (q[3:0] == 4'd9) q_next = {q[7:4] + 4'd1, 4'd0};
      else                q_next = {q[7:4], q[3:0] + 4'd1};
    end else if (dec && q != 8'h00) begin
      if (q[3:0] == 4'd0) q_next = {q[7:4] - 4'd1, 4'd9};
      else                q_next = {q[7:4], q[3:0] - 4'd1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 8'h00;
    else     q <= q_next;
  end

endmodule

// File: rtl/maze_game_core.sv
// Maze game engine: player position, wall/edge collision, BCD step counter,
// BCD countdown and the IDLE/PLAY/WIN/LOSE state machine.
module maze_game_core
  import maze_pkg::*;
#(
  parameter int MAP_DIM    = 8,
  parameter int TIME_LIMIT = 30
) (
  input  logic              clk,
  input  logic              res,
  maze_game_core_if.slave   bus
);

  localparam int         CW       = $clog2(MAP_DIM);
  localparam int         IW       = $clog2(MAP_DIM * MAP_DIM);
  localparam logic [7:0] TIME_BCD = to_bcd(TIME_LIMIT);

  state_t                     state_q, state_d;
  logic [CW-1:0]              row_q, col_q, row_d, col_d;
  logic [CW-1:0]              goal_row_q, goal_col_q;
  logic [MAP_DIM*MAP_DIM-1:0] map_q;
  logic                       bump_q, bump_d;

  logic [CW-1:0] tgt_row, tgt_col;
  logic [IW-1:0] wall_idx;
  logic          off_map, one_hot, move_valid, hit, accept, time_dec, time_zero_next;
  logic [7:0]    steps_q, time_q;

  assign one_hot    = (bus.move != 4'd0) && ((bus.move & (bus.move - 4'd1)) == 4'd0);
  assign move_valid = (state_q == ST_PLAY) && !bus.start && one_hot;
  assign time_dec   = (state_q == ST_PLAY) && !bus.start && bus.tick;

  // Target cell for the single set direction; an edge crossing leaves the
  // target on the current cell so the wall lookup index stays in range.
  always_comb begin
    tgt_row = row_q;
    tgt_col = col_q;
    off_map = 1'b0;
    if (bus.move[DIR_DOWN]) begin
      if (row_q == CW'(MAP_DIM - 1)) off_map = 1'b1;
      else                           tgt_row = row_q + CW'(1);
    end else if (bus.move[DIR_UP]) begin
      if (row_q == '0) off_map = 1'b1;
      else             tgt_row = row_q - CW'(1);
    end else if (bus.move[DIR_LEFT]) begin
      if (col_q == '0) off_map = 1'b1;
      else             tgt_col = col_q - CW'(1);
    end else if (bus.move[DIR_RIGHT]) begin
      if (col_q == CW'(MAP_DIM - 1)) off_map = 1'b1;
      else                           tgt_col = col_q + CW'(1);
    end
  end

  assign wall_idx = IW'(tgt_row) * IW'(MAP_DIM) + IW'(tgt_col);
  assign hit      = off_map || map_q[wall_idx];
  assign accept   = move_valid && !hit;
  assign bump_d   = move_valid && hit;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (bus.start) begin
      row_d = bus.start_row;
      col_d = bus.start_col;
    end else if (accept) begin
      row_d = tgt_row;
      col_d = tgt_col;
    end
  end

  // Countdown value after this edge is zero when already empty or leaving 01.
  assign time_zero_next = (time_q == 8'h00) || (time_q == 8'h01 && time_dec);

  always_comb begin
    state_d = state_q;
    if (bus.start) begin
      state_d = ST_PLAY;
    end else if (state_q == ST_PLAY) begin
      if (row_d == goal_row_q && col_d == goal_col_q) state_d = ST_WIN;
      else if (time_zero_next)                        state_d = ST_LOSE;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      row_q      <= '0;
      col_q      <= '0;
      bump_q     <= 1'b0;
      map_q      <= '0;
      goal_row_q <= '0;
      goal_col_q <= '0;
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      bump_q <= bump_d;
      if (bus.start) begin
        map_q      <= bus.wall_map;
        goal_row_q <= bus.goal_row;
        goal_col_q <= bus.goal_col;
      end
    end
  end

  bcd2_counter u_steps (
    .clk      (clk),
    .rst      (res),
    .load     (bus.start),
    .load_val (8'h00),
    .inc      (accept),
    .dec      (1'b0),
    .q        (steps_q)
  );

  bcd2_counter u_time (
    .clk      (clk),
    .rst      (res),
    .load     (bus.start),
    .load_val (TIME_BCD),
    .inc      (1'b0),
    .dec      (time_dec),
    .q        (time_q)
  );

  assign bus.state_o   = state_q;
  assign bus.row_o     = row_q;
  assign bus.col_o     = col_q;
  assign bus.steps_bcd = steps_q;
  assign bus.time_bcd  = time_q;
  assign bus.win_o     = (state_q == ST_WIN);
  assign bus.lose_o    = (state_q == ST_LOSE);
  assign bus.bump_o    = bump_q;

endmodule

// File: tb/tb_maze_game_core.sv
// Bench for maze_game_core: an 8x8 instance (3 s limit) and a 5x5 instance
// (27 s limit), checked cycle by cycle against hand-derived expectations.
module tb_maze_game_core;

  localparam int W = 27;

  logic clk = 1'b0;
  logic res;

  always #5 clk = ~clk;

  maze_game_core_if #(.MAP_DIM(8)) a_if ();
  maze_game_core_if #(.MAP_DIM(5)) b_if ();

  maze_game_core #(.MAP_DIM(8), .TIME_LIMIT(3)) dut_a (
    .clk (clk),
    .res (res),
    .bus (a_if.slave)
  );

  maze_game_core #(.MAP_DIM(5), .TIME_LIMIT(27)) dut_b (
    .clk (clk),
    .res (res),
    .bus (b_if.slave)
  );

  logic [W-1:0] exp_q[$];
  int vectors     = 0;
  int miscompares = 0;

  // {state, row, col, steps, time, win, lose, bump}
  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got st=%b r=%0d c=%0d steps=%h time=%h w/l/b=%b expected st=%b r=%0d c=%0d steps=%h time=%h w/l/b=%b",
               tag, got[26:25], got[24:22], got[21:19], got[18:11], got[10:3], got[2:0],
               exp[26:25], exp[24:22], exp[21:19], exp[18:11], exp[10:3], exp[2:0]);
    end
  endtask

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [W-1:0] pack(input logic [1:0] st, input int r, input int c,
                                        input logic [7:0] steps, input logic [7:0] time_v,
                                        input logic bump);
    return {st, 3'(r), 3'(c), steps, time_v, (st == 2'b10), (st == 2'b11), bump};
  endfunction

  function automatic logic [W-1:0] obs_a();
    return {a_if.state_o, a_if.row_o, a_if.col_o, a_if.steps_bcd, a_if.time_bcd,
            a_if.win_o, a_if.lose_o, a_if.bump_o};
  endfunction

  function automatic logic [W-1:0] obs_b();
    return {b_if.state_o, b_if.row_o, b_if.col_o, b_if.steps_bcd, b_if.time_bcd,
            b_if.win_o, b_if.lose_o, b_if.bump_o};
  endfunction

  task automatic step_a(input string tag, input logic s, input logic [3:0] mv, input logic tk,
                        input logic [W-1:0] exp);
    @(negedge clk);
    a_if.start = s;
    a_if.move  = mv;
    a_if.tick  = tk;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    a_if.start = 1'b0;
    a_if.move  = 4'd0;
    a_if.tick  = 1'b0;
    check_eq(tag, obs_a(), exp_q.pop_front());
  endtask

  task automatic step_b(input string tag, input logic s, input logic [3:0] mv, input logic tk,
                        input logic [W-1:0] exp);
    @(negedge clk);
    b_if.start = s;
    b_if.move  = mv;
    b_if.tick  = tk;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    b_if.start = 1'b0;
    b_if.move  = 4'd0;
    b_if.tick  = 1'b0;
    check_eq(tag, obs_b(), exp_q.pop_front());
  endtask

  initial begin
    res            = 1'b1;
    a_if.start     = 1'b0;
    a_if.move      = 4'd0;
    a_if.tick      = 1'b0;
    a_if.wall_map  = 64'h100;
    a_if.start_row = 3'd0;
    a_if.start_col = 3'd0;
    a_if.goal_row  = 3'd0;
    a_if.goal_col  = 3'd2;
    b_if.start     = 1'b0;
    b_if.move      = 4'd0;
    b_if.tick      = 1'b0;
    b_if.wall_map  = 25'h80;
    b_if.start_row = 3'd0;
    b_if.start_col = 3'd0;
    b_if.goal_row  = 3'd4;
    b_if.goal_col  = 3'd4;

    repeat (2) @(negedge clk);
    res = 1'b0;

    // Reset values and IDLE ignoring stimulus
    step_a("rst_idle", 0, 4'b0000, 0, pack(2'b00, 0, 0, 8'h00, 8'h00, 0));
    step_a("idle_ign", 0, 4'b1000, 1, pack(2'b00, 0, 0, 8'h00, 8'h00, 0));
    step_b("b_rst",    0, 4'b0000, 0, pack(2'b00, 0, 0, 8'h00, 8'h00, 0));

    // Moves, bumps and multi-key rejection
    step_a("start",     1, 4'b0000, 0, pack(2'b01, 0, 0, 8'h00, 8'h03, 0));
    step_a("wall_bump", 0, 4'b0001, 0, pack(2'b01, 0, 0, 8'h00, 8'h03, 1));
    step_a("bump_drop", 0, 4'b0000, 0, pack(2'b01, 0, 0, 8'h00, 8'h03, 0));
    step_a("edge_bump", 0, 4'b0010, 0, pack(2'b01, 0, 0, 8'h00, 8'h03, 1));
    step_a("right",     0, 4'b1000, 0, pack(2'b01, 0, 1, 8'h01, 8'h03, 0));
    step_a("two_keys",  0, 4'b1001, 0, pack(2'b01, 0, 1, 8'h01, 8'h03, 0));
    step_a("no_key",    0, 4'b0000, 0, pack(2'b01, 0, 1, 8'h01, 8'h03, 0));
    step_a("win",       0, 4'b1000, 0, pack(2'b10, 0, 2, 8'h02, 8'h03, 0));
    step_a("win_hold",  0, 4'b0100, 1, pack(2'b10, 0, 2, 8'h02, 8'h03, 0));

    // Timeout path
    step_a("t_start", 1, 4'b0000, 0, pack(2'b01, 0, 0, 8'h00, 8'h03, 0));
    step_a("tick2",   0, 4'b0000, 1, pack(2'b01, 0, 0, 8'h00, 8'h02, 0));
    step_a("tick1",   0, 4'b0000, 1, pack(2'b01, 0, 0, 8'h00, 8'h01, 0));
    step_a("lose",    0, 4'b0000, 1, pack(2'b11, 0, 0, 8'h00, 8'h00, 0));
    step_a("lose_ign",0, 4'b1000, 1, pack(2'b11, 0, 0, 8'h00, 8'h00, 0));

    // Winning move and timeout on the same edge
    step_a("s_start", 1, 4'b0000, 0, pack(2'b01, 0, 0, 8'h00, 8'h03, 0));
    step_a("s_right", 0, 4'b1000, 0, pack(2'b01, 0, 1, 8'h01, 8'h03, 0));
    step_a("s_tick2", 0, 4'b0000, 1, pack(2'b01, 0, 1, 8'h01, 8'h02, 0));
    step_a("s_tick1", 0, 4'b0000, 1, pack(2'b01, 0, 1, 8'h01, 8'h01, 0));
    step_a("s_both",  0, 4'b1000, 1, pack(2'b10, 0, 2, 8'h02, 8'h00, 0));

    // Start cell equal to goal
    a_if.start_row = 3'd3;
    a_if.start_col = 3'd3;
    a_if.goal_row  = 3'd3;
    a_if.goal_col  = 3'd3;
    step_a("sg_start", 1, 4'b0000, 0, pack(2'b01, 3, 3, 8'h00, 8'h03, 0));
    step_a("sg_win",   0, 4'b0000, 0, pack(2'b10, 3, 3, 8'h00, 8'h03, 0));

    // Step saturation with a far goal
    a_if.start_row = 3'd0;
    a_if.start_col = 3'd0;
    a_if.goal_row  = 3'd7;
    a_if.goal_col  = 3'd7;
    step_a("sat_start", 1, 4'b0000, 0, pack(2'b01, 0, 0, 8'h00, 8'h03, 0));
    for (int i = 1; i <= 120; i++)
      step_a("sat", 0, (i % 2 == 1) ? 4'b1000 : 4'b0100, 0,
             pack(2'b01, 0, i % 2, bcd((i > 99) ? 99 : i), 8'h03, 0));

    // Restart mid-game
    step_a("r_start", 1, 4'b0000, 0, pack(2'b01, 0, 0, 8'h00, 8'h03, 0));
    for (int i = 1; i <= 5; i++)
      step_a("r_move", 0, (i % 2 == 1) ? 4'b1000 : 4'b0100, 1'b0,
             pack(2'b01, 0, i % 2, bcd(i), 8'h03, 0));
    step_a("r_tick", 0, 4'b0000, 1, pack(2'b01, 0, 1, 8'h05, 8'h02, 0));
    a_if.start_row = 3'd2;
    a_if.start_col = 3'd2;
    step_a("restart", 1, 4'b0000, 0, pack(2'b01, 2, 2, 8'h00, 8'h03, 0));
    step_a("r_down",  0, 4'b0001, 0, pack(2'b01, 3, 2, 8'h01, 8'h03, 0));

    // Asynchronous reset between clock edges
    @(negedge clk);
    #2;
    res = 1'b1;
    exp_q.push_back(pack(2'b00, 0, 0, 8'h00, 8'h00, 0));
    #1;
    check_eq("async_rst", obs_a(), exp_q.pop_front());
    @(negedge clk);
    res = 1'b0;

    // 5x5 map: BCD borrow, non-power-of-two edge, wall lookup, BCD carry
    step_b("b_start", 1, 4'b0000, 0, pack(2'b01, 0, 0, 8'h00, 8'h27, 0));
    for (int i = 1; i <= 8; i++)
      step_b("b_tick", 0, 4'b0000, 1, pack(2'b01, 0, 0, 8'h00, bcd(27 - i), 0));
    for (int c = 1; c <= 4; c++)
      step_b("b_right", 0, 4'b1000, 0, pack(2'b01, 0, c, bcd(c), 8'h19, 0));
    step_b("b_edge", 0, 4'b1000, 0, pack(2'b01, 0, 4, 8'h04, 8'h19, 1));
    step_b("b_down", 0, 4'b0001, 0, pack(2'b01, 1, 4, 8'h05, 8'h19, 0));
    step_b("b_left", 0, 4'b0100, 0, pack(2'b01, 1, 3, 8'h06, 8'h19, 0));
    step_b("b_wall", 0, 4'b0100, 0, pack(2'b01, 1, 3, 8'h06, 8'h19, 1));
    for (int r = 2; r <= 4; r++)
      step_b("b_down", 0, 4'b0001, 0, pack(2'b01, r, 3, bcd(r + 5), 8'h19, 0));
    step_b("b_win", 0, 4'b1000, 0, pack(2'b10, 4, 4, 8'h10, 8'h19, 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
